// File: rtl/router_fsm.sv
// Packet router control FSM: decodes the header address, sequences payload/parity
// loading into the selected output FIFO, and handles full, wait-empty and soft-reset cases.
module router_fsm (
   input  logic       clock,
   input  logic       reset,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] addr;

   // Index 3 is padded with 0 so address 3 never selects a FIFO or a soft reset.
   logic [3:0] empty_vec;
   logic [3:0] soft_vec;

   assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

   // NOTE: reset applies only to the state and address flops; no memory is involved.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= DECODE_ADDRESS;
         addr  <= 2'd0;
      end else begin
         state <= state_next;
         if (state == DECODE_ADDRESS && pkt_valid)
            addr <= data_in;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid && data_in != 2'd3)
               state_next = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         WAIT_TILL_EMPTY: begin
            if (empty_vec[addr])
               state_next = LOAD_FIRST_DATA;
         end
         LOAD_FIRST_DATA: state_next = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)
               state_next = FIFO_FULL_STATE;
            else if (!pkt_valid)
               state_next = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full)
               state_next = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)
               state_next = DECODE_ADDRESS;
            else if (low_pkt_valid)
               state_next = LOAD_PARITY;
            else
               state_next = LOAD_DATA;
         end
         LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         default: state_next = DECODE_ADDRESS;
      endcase

      // A flush of the FIFO currently being addressed abandons the packet from any state.
      if (soft_vec[addr])
         state_next = DECODE_ADDRESS;
   end

   assign detect_add    = (state == DECODE_ADDRESS);
   assign lfd_state     = (state == LOAD_FIRST_DATA);
   assign ld_state      = (state == LOAD_DATA);
   assign laf_state     = (state == LOAD_AFTER_FULL);
   assign full_state    = (state == FIFO_FULL_STATE);
   assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                          (state == LOAD_PARITY);
   assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have no parameters; three output ports and a 2-bit destination address are fixed.
REQ-002 The block SHALL have one clock and its reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- pkt_valid  in  1  packet byte valid from source
- data_in  in  2  destination address, header bits [1:0]
- fifo_full  in  1  selected output FIFO full
- fifo_empty_0/1/2  in  1 each  output FIFO k empty
- soft_reset_0/1/2  in  1 each  output FIFO k timed-out/flushed
- parity_done  in  1  register block finished parity capture
- low_pkt_valid  in  1  register block saw pkt_valid fall
- detect_add  out  1  decoding header
- lfd_state  out  1  loading first data (header) byte
- ld_state  out  1  loading payload
- laf_state  out  1  loading after full
- full_state  out  1  FIFO full hold
- write_enb_reg  out  1  FIFO write enable
- rst_int_reg  out  1  clear register-block internal flags
- busy  out  1  source must hold data_in

Function
REQ-004 The block SHALL implement eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-005 In DECODE_ADDRESS with pkt_valid=1 the block SHALL latch data_in into a 2-bit addr register on the clock edge.
REQ-006 DECODE_ADDRESS SHALL go to LOAD_FIRST_DATA if pkt_valid and data_in=k (k in 0..2) and fifo_empty_k=1; to WAIT_TILL_EMPTY if pkt_valid, data_in=k and fifo_empty_k=0; otherwise it SHALL remain.
REQ-007 data_in=3 SHALL be treated as invalid: the block SHALL stay in DECODE_ADDRESS with no write.
REQ-008 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when fifo_empty of the latched addr is 1; otherwise it SHALL remain.
REQ-009 LOAD_FIRST_DATA SHALL go to LOAD_DATA unconditionally after 1 cycle.
REQ-010 LOAD_DATA SHALL go to FIFO_FULL_STATE if fifo_full=1 (priority over pkt_valid); to LOAD_PARITY if fifo_full=0 and pkt_valid=0; otherwise it SHALL remain.
REQ-011 FIFO_FULL_STATE SHALL go to LOAD_AFTER_FULL when fifo_full=0; otherwise it SHALL remain.
REQ-012 LOAD_AFTER_FULL SHALL go to DECODE_ADDRESS if parity_done=1; to LOAD_PARITY if parity_done=0 and low_pkt_valid=1; to LOAD_DATA if both are 0.
REQ-013 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR unconditionally.
REQ-014 CHECK_PARITY_ERROR SHALL go to FIFO_FULL_STATE if fifo_full=1; otherwise to DECODE_ADDRESS.
REQ-015 Soft reset: if soft_reset_k=1 and latched addr=k, the next state SHALL be DECODE_ADDRESS, overriding all other transitions (synchronous, 1 cycle).
REQ-016 soft_reset_k for k not equal to the latched addr SHALL have no effect.
REQ-017 Outputs SHALL be Moore, decoded from the state register only (no input-to-output combinational path):
- detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; full_state=FIFO_FULL_STATE; laf_state=LOAD_AFTER_FULL; rst_int_reg=CHECK_PARITY_ERROR.
REQ-018 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_AFTER_FULL and LOAD_PARITY only.
REQ-019 busy SHALL be 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-020 Exactly one of detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg SHALL be high in all states except LOAD_PARITY and WAIT_TILL_EMPTY, where all six SHALL be 0.

Reset
REQ-021 reset=1 SHALL asynchronously force state to DECODE_ADDRESS and addr to 0, giving detect_add=1, busy=0 and all other outputs 0.
REQ-022 Reset asserted mid-packet SHALL abandon the packet; after release the first edge SHALL evaluate DECODE_ADDRESS transitions.

Verification
REQ-023 Addr 1, FIFO 1 empty, 3 payload bytes, then parity: states DECODE->LFD->LD x3->LP->CPE->DECODE; write_enb_reg=1 for 4 cycles; busy=0 during LD.
REQ-024 Addr 2, fifo_empty_2=0 for 5 cycles: WAIT_TILL_EMPTY for 5 cycles with busy=1, then LFD on the first cycle after fifo_empty_2=1.
REQ-025 fifo_full=1 in LD for 3 cycles: FFS for 3 cycles with write_enb_reg=0, then LAF; with low_pkt_valid=1 and parity_done=0 -> LP -> CPE.
REQ-026 Addr 0 packet with soft_reset_0=1 during LD: DECODE_ADDRESS next cycle; soft_reset_1=1 in the same scenario causes no change.
REQ-027 data_in=3 with pkt_valid=1: stays in DECODE_ADDRESS with write_enb_reg=0; reset pulse in FFS: detect_add=1 immediately, without waiting for a clock edge.
